wb_write_arbiter: RTL

- Writeback-side producer for the register file write port (rd / indata / RegWrite).
- Merges results from the load unit and the ALU into one in-order write queue and drains one write per cycle into the register file.
- Optionally returns pending-write data to the operand-read side, so reads never see stale values while writes are queued.

---
 rtl/wb_write_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: in-order writeback queue merging load and ALU results.
// Define WB_BYPASS_EN to build the pending-write bypass lookup.
module wb_write_arbiter #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] indata,
  output logic            RegWrite,
  output logic [CW-1:0]   pending,
  output logic            idle,
  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  output logic            q_rs1_hit,
  output logic            q_rs2_hit,
  output logic [XLEN-1:0] q_rs1_data,
  output logic [XLEN-1:0] q_rs2_data
);

  logic [AW-1:0]   q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   tail2;
  logic [CW-1:0]   count;
  logic            ld_push;
  logic            alu_push;
  logic            pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Readiness looks only at registered count so two pushes always fit.
  assign ld_ready  = count <= CW'(DEPTH - 1);
  assign alu_ready = count <= CW'(DEPTH - 2);
  assign ld_push   = ld_valid && ld_ready && (ld_rd != '0);
  assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
  assign pop       = count != '0;
  assign tail2     = ld_push ? inc(tail) : tail;
  assign pending   = count;
  assign idle      = (count == '0) && !RegWrite;

  always_ff @(posedge CLK) begin
    if (ld_push) begin
      q_rd[tail]   <= ld_rd;
      q_data[tail] <= ld_data;
    end
    if (alu_push) begin
      q_rd[tail2]   <= alu_rd;
      q_data[tail2] <= alu_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rd       <= '0;
      indata   <= '0;
      RegWrite <= 1'b0;
    end else begin
      tail     <= alu_push ? inc(tail2) : tail2;
      count    <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
      RegWrite <= pop;
      if (pop) begin
        head   <= inc(head);
        rd     <= q_rd[head];
        indata <= q_data[head];
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic [1:0][AW-1:0]   qs;
  logic [1:0]           hits;
  logic [1:0][XLEN-1:0] datas;
  int                   s;

  assign qs = {q_rs2, q_rs1};

  // Scan oldest to youngest so the tail-most match overrides.
  always_comb begin
    hits  = '0;
    datas = '0;
    s     = 0;
    for (int p = 0; p < 2; p++) begin
      if (RegWrite && rd == qs[p]) begin
        hits[p]  = 1'b1;
        datas[p] = indata;
      end
      for (int i = 0; i < DEPTH; i++) begin
        s = int'(head) + i;
        if (s >= DEPTH) s = s - DEPTH;
        if (CW'(i) < count && q_rd[PW'(s)] == qs[p]) begin
          hits[p]  = 1'b1;
          datas[p] = q_data[PW'(s)];
        end
      end
      if (qs[p] == '0) begin
        hits[p]  = 1'b0;
        datas[p] = '0;
      end
    end
  end

  assign q_rs1_hit  = hits[0];
  assign q_rs2_hit  = hits[1];
  assign q_rs1_data = datas[0];
  assign q_rs2_data = datas[1];
`else
  logic unused_rs;
  assign unused_rs  = ^{q_rs1, q_rs2};
  assign q_rs1_hit  = 1'b0;
  assign q_rs2_hit  = 1'b0;
  assign q_rs1_data = '0;
  assign q_rs2_data = '0;
`endif

endmodule
